// File: rtl/peripheral_dsa_mod_mul.sv
// Modular multiplier R = (A*B) mod M using MSB-first interleaved shift-add.
// One multiplier bit is consumed per clock, so a result takes DATA_SIZE cycles
// from the edge that accepts START to the READY strobe.
module peripheral_dsa_mod_mul #(
    parameter int DATA_SIZE = 512
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic [DATA_SIZE-1:0] MODULO_IN,
    input  logic [DATA_SIZE-1:0] DATA_A_IN,
    input  logic [DATA_SIZE-1:0] DATA_B_IN,
    output logic                 BUSY,
    output logic                 READY,
    output logic [DATA_SIZE-1:0] DATA_OUT
);

    localparam int CW = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_ITERATE
    } state_t;

    state_t               state_q, state_d;
    logic [DATA_SIZE-1:0] m_q, m_d;
    logic [DATA_SIZE-1:0] a_q, a_d;
    logic [DATA_SIZE-1:0] b_q, b_d;
    logic [DATA_SIZE-1:0] r_q, r_d;
    logic [DATA_SIZE-1:0] out_q, out_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 ready_q, ready_d;

    // One extra bit on every intermediate value so 2R and R+A never lose a carry.
    logic [DATA_SIZE:0]   m_ext;
    logic [DATA_SIZE:0]   dbl;
    logic [DATA_SIZE:0]   dbl_red;
    logic [DATA_SIZE:0]   sum;
    logic [DATA_SIZE:0]   sum_red;
    logic [DATA_SIZE-1:0] step_r;

    // One iteration step: double, reduce, conditionally add A, reduce again.
    always_comb begin
        m_ext   = {1'b0, m_q};
        dbl     = {r_q, 1'b0};
        dbl_red = (dbl >= m_ext) ? (dbl - m_ext) : dbl;
        sum     = b_q[cnt_q] ? (dbl_red + {1'b0, a_q}) : dbl_red;
        sum_red = (sum >= m_ext) ? (sum - m_ext) : sum;
        // A zero modulus would let the accumulator grow unreduced; pin it to 0.
        step_r  = (m_q == '0) ? '0 : sum_red[DATA_SIZE-1:0];
    end

    // Next-state logic: capture operands in IDLE, step the accumulator in ITERATE.
    always_comb begin
        // NOTE: every _d defaults to its _q first, so no branch can infer a latch.
        state_d = state_q;
        m_d     = m_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        ready_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    m_d     = MODULO_IN;
                    a_d     = DATA_A_IN;
                    b_d     = DATA_B_IN;
                    r_d     = '0;
                    cnt_d   = CW'(DATA_SIZE - 1);
                    state_d = ST_ITERATE;
                end
            end
            ST_ITERATE: begin
                r_d = step_r;
                if (cnt_q == '0) begin
                    out_d   = step_r;
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous active-high clear.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            // NOTE: operand and accumulator registers are cleared too, so an aborted run leaves no residue.
            state_q <= ST_IDLE;
            m_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            state_q <= state_d;
            m_q     <= m_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    assign BUSY     = (state_q == ST_ITERATE);
    assign READY    = ready_q;
    assign DATA_OUT = out_q;

endmodule

// File: tb/tb_peripheral_dsa_mod_mul.sv
// Self-checking bench for peripheral_dsa_mod_mul: three instances (512, 256 and
// 16 bits) share one driven operand bus; a wide-arithmetic reference model
// supplies every expected result.
module tb_peripheral_dsa_mod_mul;

    typedef logic [511:0] w512_t;

    localparam w512_t SECP256_P = {256'd0,
        256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F};
    localparam w512_t SECP256_X = {256'd0,
        256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798};
    localparam w512_t BLACKPOOL512_P = {{15{32'hFFFFFFFF}}, 32'hFFFFFDC7};
    localparam w512_t BLACKPOOL512_X = {64'h3A5F9C2E71B04D86, 64'h9E1172C5AB3F0D64,
        64'h5C8E2A917FD3B046, 64'hD17A4C0E93B56F28, 64'h0B6E39F4C2A8157D,
        64'h84F2D61B3A9C0E57, 64'h6AD0B3E52F4817C9, 64'hE39C72A10B5D4F86};
    localparam w512_t BLACKPOOL512_Y = {64'h71C3E8B4926D0FA5, 64'h2B94D0E6A13F7C58,
        64'hC60A5F3B8E1D2947, 64'h1F8B7246D3CA950E, 64'hA45E1C93706BD2F8,
        64'h3D76F0A82C5E41B9, 64'h9B2C4E7F160A83D5, 64'h58E0D39A4B71C62F};

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    logic  start = 1'b0;
    int    sel = 0;
    w512_t m_in = '0;
    w512_t a_in = '0;
    w512_t b_in = '0;

    logic          busy_512, ready_512, busy_256, ready_256, busy_16, ready_16;
    logic [511:0]  dout_512;
    logic [255:0]  dout_256;
    logic [15:0]   dout_16;
    logic          busy_m, ready_m;
    w512_t         dout_m;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    peripheral_dsa_mod_mul #(.DATA_SIZE(512)) dut_512 (
        .CLK(clk), .RST(rst), .START(start && sel == 0),
        .MODULO_IN(m_in), .DATA_A_IN(a_in), .DATA_B_IN(b_in),
        .BUSY(busy_512), .READY(ready_512), .DATA_OUT(dout_512));

    peripheral_dsa_mod_mul #(.DATA_SIZE(256)) dut_256 (
        .CLK(clk), .RST(rst), .START(start && sel == 1),
        .MODULO_IN(m_in[255:0]), .DATA_A_IN(a_in[255:0]), .DATA_B_IN(b_in[255:0]),
        .BUSY(busy_256), .READY(ready_256), .DATA_OUT(dout_256));

    peripheral_dsa_mod_mul #(.DATA_SIZE(16)) dut_16 (
        .CLK(clk), .RST(rst), .START(start && sel == 2),
        .MODULO_IN(m_in[15:0]), .DATA_A_IN(a_in[15:0]), .DATA_B_IN(b_in[15:0]),
        .BUSY(busy_16), .READY(ready_16), .DATA_OUT(dout_16));

    always_comb begin
        case (sel)
            0:       begin busy_m = busy_512; ready_m = ready_512; dout_m = dout_512; end
            1:       begin busy_m = busy_256; ready_m = ready_256; dout_m = {256'd0, dout_256}; end
            default: begin busy_m = busy_16;  ready_m = ready_16;  dout_m = {496'd0, dout_16}; end
        endcase
    end

    function automatic int width_of(input int s);
        return (s == 0) ? 512 : (s == 1) ? 256 : 16;
    endfunction

    // Reference model: plain wide multiply and modulo; a zero modulus yields 0.
    function automatic w512_t ref_mod_mul(input w512_t m, input w512_t a, input w512_t b);
        logic [1023:0] prod;
        if (m == '0) return '0;
        prod = {512'd0, a} * {512'd0, b};
        return w512_t'(prod % {512'd0, m});
    endfunction

    function automatic w512_t rand512();
        w512_t v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic start_op(input int s, input w512_t m, input w512_t a, input w512_t b);
        @(negedge clk);
        sel = s; m_in = m; a_in = a; b_in = b; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits (bounded) for READY; lat counts edges since the START-sampling edge.
    task automatic wait_ready(input int lat0, input int limit, output int lat,
                              output bit busy_ok, output bit hold_ok);
        w512_t d0;
        d0 = dout_m; lat = lat0; busy_ok = 1'b1; hold_ok = 1'b1;
        while (ready_m !== 1'b1 && lat < limit) begin
            if (busy_m !== 1'b1) busy_ok = 1'b0;
            if (dout_m !== d0) hold_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (ready_m === 1'b1 && busy_m !== 1'b0) busy_ok = 1'b0;
    endtask

    task automatic run_op(input int s, input w512_t m, input w512_t a, input w512_t b,
                          output w512_t dout, output int lat, output bit busy_ok, output bit hold_ok);
        start_op(s, m, a, b);
        wait_ready(0, width_of(s) + 16, lat, busy_ok, hold_ok);
        dout = dout_m;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy_512, ready_512, busy_256, ready_256, busy_16, ready_16} !== 6'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 000000",
                {busy_512, ready_512, busy_256, ready_256, busy_16, ready_16});
        end
        n_checks++;
        if (dout_512 !== '0 || dout_256 !== '0 || dout_16 !== '0) begin
            n_fail++; $display("FAIL reset_dout: got %0h/%0h/%0h expected 0", dout_512, dout_256, dout_16);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        w512_t d; int lat; bit bok, hok;
        run_op(0, 512'd7, 512'd3, 512'd5, d, lat, bok, hok);
        n_checks++;
        if (lat !== 512) begin n_fail++; $display("FAIL basic_latency: got %0d expected 512", lat); end
        n_checks++;
        if (d !== 512'd1) begin n_fail++; $display("FAIL basic_result: got %0h expected 1", d); end
        n_checks++;
        if (!bok) begin n_fail++; $display("FAIL basic_busy_window: got 0 expected 1"); end
        n_checks++;
        if (!hok) begin n_fail++; $display("FAIL basic_dout_hold_during_op: got 0 expected 1"); end
        @(negedge clk);
        n_checks++;
        if (ready_m !== 1'b0) begin n_fail++; $display("FAIL basic_ready_one_cycle: got %b expected 0", ready_m); end
        repeat (5) @(negedge clk);
        n_checks++;
        if (dout_m !== 512'd1 || busy_m !== 1'b0) begin
            n_fail++; $display("FAIL basic_idle_hold: got dout=%0h busy=%b expected 1/0", dout_m, busy_m);
        end
    endtask

    task automatic test_secp256();
        w512_t d; int lat; bit bok, hok;
        run_op(1, SECP256_P, SECP256_X, 512'd1, d, lat, bok, hok);
        n_checks++;
        if (d !== SECP256_X || lat !== 256) begin
            n_fail++; $display("FAIL secp_x_times_1: got %0h lat %0d expected %0h lat 256", d, lat, SECP256_X);
        end
        run_op(1, SECP256_P, SECP256_P - 1, SECP256_P - 1, d, lat, bok, hok);
        n_checks++;
        if (d !== 512'd1) begin n_fail++; $display("FAIL secp_m1_squared: got %0h expected 1", d); end
    endtask

    task automatic test_blackpool();
        w512_t d, exp; int lat; bit bok, hok;
        exp = ref_mod_mul(BLACKPOOL512_P, BLACKPOOL512_X, BLACKPOOL512_Y);
        run_op(0, BLACKPOOL512_P, BLACKPOOL512_X, BLACKPOOL512_Y, d, lat, bok, hok);
        n_checks++;
        if (d !== exp || lat !== 512) begin
            n_fail++; $display("FAIL blackpool_xy: got %0h lat %0d expected %0h lat 512", d, lat, exp);
        end
        run_op(0, BLACKPOOL512_P, '0, BLACKPOOL512_Y, d, lat, bok, hok);
        n_checks++;
        if (d !== '0) begin n_fail++; $display("FAIL blackpool_a0: got %0h expected 0", d); end
    endtask

    task automatic test_back_to_back();
        w512_t d, exp1, exp2; int lat; bit bok, hok;
        exp1 = ref_mod_mul(BLACKPOOL512_P, BLACKPOOL512_Y, BLACKPOOL512_X - 3);
        exp2 = ref_mod_mul(512'd99991, 512'd12345, 512'd6789);
        start_op(0, BLACKPOOL512_P, BLACKPOOL512_Y, BLACKPOOL512_X - 3);
        repeat (49) @(negedge clk);
        // Re-pulse START and scramble the operand bus mid-run.
        start = 1'b1; m_in = 512'd11; a_in = 512'd4; b_in = 512'd9;
        @(negedge clk);
        start = 1'b0; m_in = rand512(); a_in = rand512(); b_in = rand512();
        wait_ready(50, 530, lat, bok, hok);
        n_checks++;
        if (lat !== 512 || dout_m !== exp1) begin
            n_fail++; $display("FAIL midop_ignored: got %0h lat %0d expected %0h lat 512", dout_m, lat, exp1);
        end
        n_checks++;
        if (!bok) begin n_fail++; $display("FAIL midop_busy_window: got 0 expected 1"); end
        // START in the READY cycle must be taken with no dead cycle.
        m_in = 512'd99991; a_in = 512'd12345; b_in = 512'd6789; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (ready_m !== 1'b0 || busy_m !== 1'b1) begin
            n_fail++; $display("FAIL b2b_accept: got ready=%b busy=%b expected 0/1", ready_m, busy_m);
        end
        wait_ready(0, 530, lat, bok, hok);
        n_checks++;
        if (lat !== 512 || dout_m !== exp2) begin
            n_fail++; $display("FAIL b2b_second: got %0h lat %0d expected %0h lat 512", dout_m, lat, exp2);
        end
    endtask

    task automatic test_reset_abort();
        w512_t d; int lat; bit bok, hok; bit quiet;
        start_op(0, 512'd7, 512'd3, 512'd5);
        repeat (99) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (busy_m !== 1'b0 || ready_m !== 1'b0 || dout_m !== '0) begin
            n_fail++; $display("FAIL abort_async_clear: got busy=%b ready=%b dout=%0h expected 0/0/0",
                busy_m, ready_m, dout_m);
        end
        @(negedge clk);
        rst = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (ready_m !== 1'b0 || busy_m !== 1'b0) quiet = 1'b0;
        end
        n_checks++;
        if (!quiet) begin n_fail++; $display("FAIL abort_no_ready: got 0 expected 1"); end
        run_op(0, 512'd13, 512'd12, 512'd11, d, lat, bok, hok);
        n_checks++;
        if (d !== 512'd2 || lat !== 512) begin
            n_fail++; $display("FAIL abort_restart: got %0h lat %0d expected 2 lat 512", d, lat);
        end
    endtask

    task automatic test_mod_edges();
        w512_t d; int lat; bit bok, hok;
        run_op(0, '0, 512'd5, 512'd7, d, lat, bok, hok);
        n_checks++;
        if (d !== '0 || lat !== 512) begin
            n_fail++; $display("FAIL mod_zero: got %0h lat %0d expected 0 lat 512", d, lat);
        end
        run_op(2, 512'd1, 512'd0, 512'hBEEF, d, lat, bok, hok);
        n_checks++;
        if (d !== '0 || lat !== 16) begin
            n_fail++; $display("FAIL mod_one: got %0h lat %0d expected 0 lat 16", d, lat);
        end
        run_op(2, 512'd5, 512'hFFFF, 512'hFFFF, d, lat, bok, hok);
        n_checks++;
        if (lat !== 16) begin n_fail++; $display("FAIL a_ge_m_latency: got %0d expected 16", lat); end
    endtask

    task automatic test_random();
        w512_t d, m, a, b, exp; int lat; bit bok, hok;
        for (int i = 0; i < 1016; i++) begin
            int s;
            s = (i < 1000) ? 2 : (i < 1008) ? 0 : 1;
            if (s == 0) begin
                m = rand512();
                if (m == '0) m = 512'd3;
                a = rand512() % m; b = rand512();
            end else if (s == 1) begin
                m = {256'd0, rand512() >> 256};
                if (m == '0) m = 512'd3;
                a = rand512() % m; b = {256'd0, rand512() >> 256};
            end else begin
                m = 512'($urandom_range(1, 65535));
                a = 512'($urandom) % m; b = 512'($urandom_range(0, 65535));
            end
            exp = ref_mod_mul(m, a, b);
            run_op(s, m, a, b, d, lat, bok, hok);
            n_checks++;
            if (d !== exp || lat !== width_of(s)) begin
                n_fail++; $display("FAIL random_%0d: got %0h lat %0d expected %0h lat %0d",
                    i, d, lat, exp, width_of(s));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_secp256();
        test_blackpool();
        test_back_to_back();
        test_reset_abort();
        test_mod_edges();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/peripheral_dsa_mod_mul.md
PERIPHERAL_DSA_MOD_MUL -- requirements
Module: peripheral_dsa_mod_mul

Interface
REQ-001 SHALL have parameter: DATA_SIZE, 512, operand/modulus width in bits (matches the package system width; 256 for SECP256 use).
REQ-002 SHALL have ports:
  CLK  input  1  single clock; all state updates on its rising edge.
  RST  input  1  asynchronous, active-high reset.
  START  input  1  request pulse; sampled only in IDLE.
  MODULO_IN  input  DATA_SIZE  modulus M (e.g. curve P or N).
  DATA_A_IN  input  DATA_SIZE  multiplicand A; caller guarantees A < M.
  DATA_B_IN  input  DATA_SIZE  multiplier B; any value.
  BUSY  output  1  high while an operation is in progress.
  READY  output  1  one-cycle completion strobe.
  DATA_OUT  output  DATA_SIZE  result (A*B) mod M; held until next completion.
REQ-003 SHALL use one clock domain; reset is asynchronous and active-high, all other inputs synchronous.

Function
REQ-004 SHALL compute R = (A*B) mod M by MSB-first interleaved shift-add, one multiplier bit per cycle.
REQ-005 SHALL have states IDLE and ITERATE.
REQ-006 IDLE with START=1 at a rising edge: SHALL capture MODULO_IN, DATA_A_IN, DATA_B_IN into internal registers, clear accumulator, set bit counter to DATA_SIZE-1, enter ITERATE, assert BUSY.
REQ-007 IDLE with START=0: SHALL hold all state and outputs.
REQ-008 Each ITERATE edge, bit i = counter: T = 2R; if T >= M then T = T - M; if B[i] then T = T + A; if T >= M then T = T - M; R = T.
REQ-009 Intermediate sums SHALL be DATA_SIZE+1 bits wide; no carry lost; R always < M after each step.
REQ-010 Counter SHALL decrement by one per ITERATE edge; edge processing bit 0 SHALL load DATA_OUT with final R, set READY=1, clear BUSY, return to IDLE.
REQ-011 Latency: READY SHALL rise exactly DATA_SIZE edges after the edge that sampled START (512 cycles at default).
REQ-012 READY SHALL be high for exactly one cycle per accepted START.
REQ-013 START during ITERATE SHALL be ignored; inputs may change freely during ITERATE without affecting the result.
REQ-014 START high in the READY cycle SHALL be accepted (state is IDLE), giving back-to-back operations with no dead cycle.
REQ-015 MODULO_IN == 0 captured: SHALL run the same latency and produce DATA_OUT = 0.
REQ-016 MODULO_IN == 1 captured: result SHALL be 0 by the same arithmetic (no special case needed).
REQ-017 A >= M: result unspecified; no hang; READY still issued at normal latency.
REQ-018 DATA_OUT SHALL change only on a completion edge or reset.

Reset
REQ-019 RST high SHALL immediately (asynchronously) force state IDLE, BUSY=0, READY=0, DATA_OUT=0, accumulator, counter and captured operands to 0.
REQ-020 RST asserted mid-ITERATE SHALL abort the operation; no READY SHALL be issued for it after release.
REQ-021 First START after RST release SHALL be accepted normally.

Verification
REQ-022 Bench SHALL cover, at DATA_SIZE=512 unless stated:
  a) A=3, B=5, M=7, START one cycle -> READY exactly 512 cycles later, DATA_OUT=1, BUSY high for those 512 cycles.
  b) DATA_SIZE=256: A=SECP256_X, B=1, M=SECP256_P -> DATA_OUT=SECP256_X; A=M-1, B=M-1 -> DATA_OUT=1.
  c) A=BLACKPOOL512_X, B=BLACKPOOL512_Y, M=BLACKPOOL512_P -> DATA_OUT equals reference model (X*Y) mod P; A=0 -> 0.
  d) START re-pulsed and inputs changed mid-ITERATE -> ignored; single READY, result of the original operands; then START in the READY cycle -> second READY 512 cycles later.
  e) RST pulsed at cycle 100 of an operation -> outputs 0 immediately, no READY ever for that operation; next START completes correctly.
  f) M=0 -> READY at normal latency with DATA_OUT=0; 1000 random reduced operand sets vs. reference model, zero mismatches.
